key_cmd: RTL and testbench

- Input-conditioning stage directly upstream of the game state machine and the jump/score logic.
- Converts keyboard decoder outputs (key_down map, last_change, key_valid) and raw board buttons into clean, single-cycle game commands plus a few levels: jump, jump-hold, duck, restart, pause.
- Replaces the ad-hoc OR of key bits and the button debounce/onepulse chain.
- All outputs are registered and synchronous to clk.

---
 rtl/key_cmd_pkg.sv | 10 +
 rtl/key_cmd_btn_filter.sv | 46 ++++
 rtl/key_cmd.sv | 129 ++++++++++++
 tb/tb_key_cmd.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/key_cmd_pkg.sv
// Scan codes shared by the input-conditioning stage and other game blocks.
// Bit 8 marks an E0-prefixed (extended) code.
package key_cmd_pkg;
  localparam logic [8:0] SC_SPACE = 9'h029;
  localparam logic [8:0] SC_UP    = 9'h175;
  localparam logic [8:0] SC_DOWN  = 9'h172;
  localparam logic [8:0] SC_R     = 9'h02D;
  localparam logic [8:0] SC_P     = 9'h04D;
  localparam logic [8:0] SC_Q     = 9'h015;
endpackage

// File: rtl/key_cmd_btn_filter.sv
// Raw button conditioning: a 2-flop synchroniser, then a stable-count debounce.
// The filtered level follows the synced input only after DB_CYCLES consecutive differing cycles.
module btn_filter #(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_db
);
  logic        sync0_q, sync0_d;
  logic        sync1_q, sync1_d;
  logic        level_q, level_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    sync0_d = btn_raw;
    sync1_d = sync0_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any cycle where the synced input matches the level restarts the count.
    if (sync1_q != level_q) begin
      if (cnt_q == DB_CYCLES - 16'd1) begin
        level_d = sync1_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_db = level_q;
endmodule

// File: rtl/key_cmd.sv
// Turns keyboard key maps and board buttons into registered game commands:
// single-cycle jump/restart pulses plus jump_hold, duck and paused levels.
module key_cmd #(
  parameter logic [15:0] DB_CYCLES       = 16'd50000,
  parameter logic [3:0]  COOLDOWN_FRAMES = 4'd6,
  parameter logic [4:0]  HOLD_MAX_FRAMES = 5'd20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] key_down,
  input  logic [8:0]   last_change,
  input  logic         key_valid,
  input  logic         btn_jump,
  input  logic         btn_rst,
  input  logic         frame_tick,
  output logic         jump_pulse,
  output logic         jump_hold,
  output logic         duck,
  output logic         restart_pulse,
  output logic         paused
);
  import key_cmd_pkg::*;

  logic jump_db, rst_db;
  logic jump_req, rst_req;
  logic jump_fire, restart, pause_tgl;

  logic       jump_req_q, jump_req_d;
  logic       rst_req_q, rst_req_d;
  logic       paused_q, paused_d;
  logic [3:0] cool_q, cool_d;
  logic [4:0] hold_cnt_q, hold_cnt_d;
  logic       jump_hold_q, jump_hold_d;
  logic       duck_q, duck_d;
  logic       jump_pulse_q, jump_pulse_d;
  logic       restart_pulse_q, restart_pulse_d;

  btn_filter #(.DB_CYCLES(DB_CYCLES)) u_jump_filter (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_jump), .btn_db(jump_db)
  );

  btn_filter #(.DB_CYCLES(DB_CYCLES)) u_rst_filter (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_rst), .btn_db(rst_db)
  );

  always_comb begin
    jump_req  = key_down[SC_SPACE] | key_down[SC_UP] | jump_db;
    rst_req   = key_down[SC_R] | rst_db;
    jump_fire = jump_req & ~jump_req_q & ~paused_q & (cool_q == 4'd0);
    restart   = rst_req & ~rst_req_q;
    // Only make events of P toggle; a break leaves key_down[P] low.
    pause_tgl = key_valid & (last_change == SC_P) & key_down[SC_P];
  end

  always_comb begin
    jump_req_d      = jump_req;
    rst_req_d       = rst_req;
    jump_pulse_d    = jump_fire;
    restart_pulse_d = restart;

    paused_d = paused_q;
    if (restart) begin
      paused_d = 1'b0;
    end else if (pause_tgl) begin
      paused_d = ~paused_q;
    end

    // A load always beats a coincident frame_tick.
    cool_d = cool_q;
    if (restart) begin
      cool_d = 4'd0;
    end else if (jump_fire) begin
      cool_d = COOLDOWN_FRAMES;
    end else if (frame_tick && cool_q != 4'd0) begin
      cool_d = cool_q - 4'd1;
    end

    jump_hold_d = jump_hold_q;
    hold_cnt_d  = hold_cnt_q;
    if (restart || paused_d) begin
      jump_hold_d = 1'b0;
      hold_cnt_d  = 5'd0;
    end else if (jump_fire) begin
      jump_hold_d = 1'b1;
      hold_cnt_d  = HOLD_MAX_FRAMES;
    end else if (!jump_req) begin
      jump_hold_d = 1'b0;
      hold_cnt_d  = 5'd0;
    end else if (frame_tick && hold_cnt_q != 5'd0) begin
      hold_cnt_d = hold_cnt_q - 5'd1;
      if (hold_cnt_q == 5'd1) begin
        jump_hold_d = 1'b0;
      end
    end

    // Uses next-state hold/pause so duck never flickers on during a jump start.
    duck_d = key_down[SC_DOWN] & ~jump_hold_d & ~paused_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_req_q      <= 1'b0;
      rst_req_q       <= 1'b0;
      paused_q        <= 1'b0;
      cool_q          <= '0;
      hold_cnt_q      <= '0;
      jump_hold_q     <= 1'b0;
      duck_q          <= 1'b0;
      jump_pulse_q    <= 1'b0;
      restart_pulse_q <= 1'b0;
    end else begin
      jump_req_q      <= jump_req_d;
      rst_req_q       <= rst_req_d;
      paused_q        <= paused_d;
      cool_q          <= cool_d;
      hold_cnt_q      <= hold_cnt_d;
      jump_hold_q     <= jump_hold_d;
      duck_q          <= duck_d;
      jump_pulse_q    <= jump_pulse_d;
      restart_pulse_q <= restart_pulse_d;
    end
  end

  assign jump_pulse    = jump_pulse_q;
  assign jump_hold     = jump_hold_q;
  assign duck          = duck_q;
  assign restart_pulse = restart_pulse_q;
  assign paused        = paused_q;
endmodule

// File: tb/tb_key_cmd.sv
// Directed bench for key_cmd: linear sequence of steps with hand-computed expectations.
module tb_key_cmd;
  localparam logic [8:0] K_SPACE = 9'h029;
  localparam logic [8:0] K_UP    = 9'h175;
  localparam logic [8:0] K_DOWN  = 9'h172;
  localparam logic [8:0] K_R     = 9'h02D;
  localparam logic [8:0] K_P     = 9'h04D;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] kd;
  logic [8:0]   lc;
  logic         kv, bj, br, ft;
  logic         jump_pulse, jump_hold, duck, restart_pulse, paused;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;
  int n;

  always #5 clk = ~clk;

  key_cmd dut (
    .clk(clk), .rst_n(rst_n), .key_down(kd), .last_change(lc), .key_valid(kv),
    .btn_jump(bj), .btn_rst(br), .frame_tick(ft),
    .jump_pulse(jump_pulse), .jump_hold(jump_hold), .duck(duck),
    .restart_pulse(restart_pulse), .paused(paused)
  );

  // Advance n rising edges, then park on the following falling edge.
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic frame(input int k);
    repeat (k) begin
      ft = 1'b1;
      cyc(1);
      ft = 1'b0;
      cyc(1);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pause_event(input logic make);
    kd[K_P] = make;
    lc = K_P;
    kv = 1'b1;
    cyc(1);
    kv = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; kd = '0; lc = '0; kv = 1'b0; bj = 1'b0; br = 1'b0; ft = 1'b0;
    cyc(3);
    chk("rst_jump_pulse", {31'd0, jump_pulse}, 32'd0);
    chk("rst_jump_hold", {31'd0, jump_hold}, 32'd0);
    chk("rst_duck", {31'd0, duck}, 32'd0);
    chk("rst_restart", {31'd0, restart_pulse}, 32'd0);
    chk("rst_paused", {31'd0, paused}, 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Single jump held for 100 cycles
    kd[K_SPACE] = 1'b1;
    cyc(1);
    chk("jump_first_pulse", {31'd0, jump_pulse}, 32'd1);
    chk("jump_first_hold", {31'd0, jump_hold}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 99; i++) begin
      cyc(1);
      if (jump_pulse) cnt++;
    end
    chk("jump_held_no_retrigger", cnt, 32'd0);
    chk("jump_hold_while_held", {31'd0, jump_hold}, 32'd1);
    kd[K_SPACE] = 1'b0;
    cyc(1);
    chk("jump_hold_release", {31'd0, jump_hold}, 32'd0);

    // Cooldown: re-press after 2 ticks dropped, after 7 ticks accepted
    frame(2);
    kd[K_UP] = 1'b1;
    cyc(1);
    chk("cooldown_drop", {31'd0, jump_pulse}, 32'd0);
    kd[K_UP] = 1'b0;
    cyc(1);
    frame(5);
    kd[K_UP] = 1'b1;
    cyc(1);
    chk("cooldown_expired_pulse", {31'd0, jump_pulse}, 32'd1);

    // Duck suppressed while jump_hold, then allowed after release
    kd[K_DOWN] = 1'b1;
    cyc(2);
    chk("duck_blocked_by_hold", {31'd0, duck}, 32'd0);
    kd[K_UP] = 1'b0;
    cyc(1);
    chk("duck_after_release", {31'd0, duck}, 32'd1);
    kd[K_DOWN] = 1'b0;
    cyc(1);
    chk("duck_off", {31'd0, duck}, 32'd0);

    // Hold limit of 20 frames
    frame(6);
    kd[K_SPACE] = 1'b1;
    cyc(1);
    chk("hold_jump_pulse", {31'd0, jump_pulse}, 32'd1);
    frame(19);
    chk("hold_after_19", {31'd0, jump_hold}, 32'd1);
    frame(1);
    chk("hold_after_20", {31'd0, jump_hold}, 32'd0);
    kd[K_SPACE] = 1'b0;
    cyc(1);

    // Pause toggle, blocked jump, break ignored, second make unpauses
    pause_event(1'b1);
    chk("pause_set", {31'd0, paused}, 32'd1);
    kd[K_SPACE] = 1'b1;
    cyc(1);
    chk("paused_no_jump", {31'd0, jump_pulse}, 32'd0);
    kd[K_SPACE] = 1'b0;
    cyc(1);
    pause_event(1'b0);
    chk("pause_break_ignored", {31'd0, paused}, 32'd1);
    pause_event(1'b1);
    chk("pause_cleared", {31'd0, paused}, 32'd0);
    kd[K_P] = 1'b0;
    cyc(1);

    // Restart and pause make together while a jump is active
    kd[K_SPACE] = 1'b1;
    cyc(1);
    chk("pre_restart_jump", {31'd0, jump_pulse}, 32'd1);
    kd[K_R] = 1'b1;
    pause_event(1'b1);
    chk("restart_pulse", {31'd0, restart_pulse}, 32'd1);
    chk("restart_beats_pause", {31'd0, paused}, 32'd0);
    chk("restart_clears_hold", {31'd0, jump_hold}, 32'd0);
    cyc(1);
    chk("restart_single", {31'd0, restart_pulse}, 32'd0);
    kd[K_SPACE] = 1'b0; kd[K_R] = 1'b0; kd[K_P] = 1'b0;
    cyc(2);
    kd[K_SPACE] = 1'b1;
    cyc(1);
    chk("restart_clears_cooldown", {31'd0, jump_pulse}, 32'd1);
    kd[K_SPACE] = 1'b0;
    cyc(1);

    // Reset mid-operation with paused=1 and cooldown=3
    frame(3);
    pause_event(1'b1);
    kd[K_P] = 1'b0;
    chk("pre_reset_paused", {31'd0, paused}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_paused", {31'd0, paused}, 32'd0);
    chk("async_rst_hold", {31'd0, jump_hold}, 32'd0);
    chk("async_rst_pulse", {31'd0, jump_pulse}, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (jump_pulse || restart_pulse) cnt++;
    end
    chk("post_reset_no_pulse", cnt, 32'd0);
    kd[K_SPACE] = 1'b1;
    cyc(1);
    chk("post_reset_jump", {31'd0, jump_pulse}, 32'd1);
    kd[K_SPACE] = 1'b0;
    cyc(1);
    frame(6);

    // Button bounce then stable high
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      bj = ~bj;
      for (int j = 0; j < 1000; j++) begin
        cyc(1);
        if (jump_pulse) cnt++;
      end
    end
    chk("bounce_no_pulse", cnt, 32'd0);
    bj = 1'b1;
    n = 0;
    while (n < 60000 && !jump_pulse) begin
      cyc(1);
      n++;
    end
    chk("debounce_latency", n, 32'd50003);
    cyc(1);
    chk("debounce_single_pulse", {31'd0, jump_pulse}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
